bus_arb: RTL and testbench

//   Two-master arbiter for the single system bus: shares bus_stb/we/addr/dout/din/ack/irq

---
 rtl/eco32_bus_pkg.sv | 11 +
 rtl/bus_arb_tout.sv | 22 ++
 rtl/bus_arb.sv | 81 ++++++++
 tb/tb_bus_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eco32_bus_pkg.sv
// eco32_bus_pkg: shared bus widths and arbiter state encoding
package eco32_bus_pkg;
   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT2_UNUSED_GUARD = 2'd3,
      ARB_GNT1 = 2'd2
   } arb_state_t;
endpackage

// File: rtl/bus_arb_tout.sv
// bus_arb_tout: grant watchdog, flags expiry after TOUT_CYC-1 unacknowledged grant cycles
// Compiled only when BUS_ARB_TIMEOUT_EN is defined.
`ifdef BUS_ARB_TIMEOUT_EN
module bus_arb_tout #(
   parameter int TOUT_CYC = 256,
   parameter int TOUT_W   = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ack,
   output logic expire
);
   logic [TOUT_W-1:0] cnt;
   assign expire = active && (cnt == TOUT_W'(TOUT_CYC - 1));
   // cleared whenever not granted, so every grant starts counting from zero
   always_ff @(posedge clk) begin
      if (rst || !active || ack || expire) cnt <= '0;
      else cnt <= cnt + TOUT_W'(1);
   end
endmodule
`endif

// File: rtl/bus_arb.sv
// bus_arb: round-robin two-master arbiter for the system bus (cpu = m0, dma = m1)
// Optional grant timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arb
   import eco32_bus_pkg::*;
#(
   parameter int TOUT_CYC = 256,
   parameter int TOUT_W   = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_stb,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_dout,
   output logic [DATA_W-1:0] m0_din,
   output logic              m0_ack,
   input  logic              m1_stb,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_dout,
   output logic [DATA_W-1:0] m1_din,
   output logic              m1_ack,
   output logic              bus_stb,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_dout,
   input  logic [DATA_W-1:0] bus_din,
   input  logic              bus_ack,
   output logic              tout_irq
);
   arb_state_t state;
   logic       last;
   logic       g0, g1, expire;
   if (TOUT_CYC < 2 || TOUT_CYC - 1 >= 2 ** TOUT_W) begin : g_bad_tout
      $error("bus_arb: TOUT_W too narrow for TOUT_CYC");
   end
`ifdef BUS_ARB_TIMEOUT_EN
   bus_arb_tout #(.TOUT_CYC(TOUT_CYC), .TOUT_W(TOUT_W)) u_tout (
      .clk(clk), .rst(rst), .active(g0 | g1), .ack(bus_ack), .expire(expire)
   );
`else
   assign expire = 1'b0;
`endif
   assign g0       = state == ARB_GNT0;
   assign g1       = state == ARB_GNT1;
   // a real slave ack on the expiry cycle wins over the timeout
   assign tout_irq = expire & ~bus_ack;
   always_comb begin
      bus_stb  = ((g0 & m0_stb) | (g1 & m1_stb)) & ~tout_irq;
      bus_we   = g0 ? m0_we   : g1 ? m1_we   : 1'b0;
      bus_addr = g0 ? m0_addr : g1 ? m1_addr : '0;
      bus_dout = g0 ? m0_dout : g1 ? m1_dout : '0;
      m0_ack   = g0 & (bus_ack | tout_irq);
      m1_ack   = g1 & (bus_ack | tout_irq);
      m0_din   = (g0 & ~tout_irq) ? bus_din : '0;
      m1_din   = (g1 & ~tout_irq) ? bus_din : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB_IDLE;
         last  <= 1'b1;
      end else begin
         case (state)
            ARB_IDLE:
               if (m0_stb && (!m1_stb || last)) state <= ARB_GNT0;
               else if (m1_stb) state <= ARB_GNT1;
            ARB_GNT0:
               if (bus_ack || expire) begin
                  state <= ARB_IDLE;
                  last  <= 1'b0;
               end else if (!m0_stb) state <= ARB_IDLE;
            ARB_GNT1:
               if (bus_ack || expire) begin
                  state <= ARB_IDLE;
                  last  <= 1'b1;
               end else if (!m1_stb) state <= ARB_IDLE;
            default: state <= ARB_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: directed self-checking bench for bus_arb
// Timeout scenarios run when BUS_ARB_TIMEOUT_EN is defined (TOUT_CYC=8).
module tb_bus_arb;
`ifdef BUS_ARB_TIMEOUT_EN
   localparam int TC = 8;
   localparam int TW = 4;
`else
   localparam int TC = 256;
   localparam int TW = 9;
`endif
   localparam logic [29:0] A0 = 30'h08000000;
   localparam logic [29:0] A1 = 30'h00000100;
   logic clk = 1'b0, rst = 1'b1;
   logic m0_stb, m0_we, m1_stb, m1_we, bus_ack;
   logic [29:0] m0_addr, m1_addr;
   logic [31:0] m0_dout, m1_dout, bus_din;
   logic [31:0] m0_din, m1_din, bus_dout;
   logic m0_ack, m1_ack, bus_stb, bus_we, tout_irq;
   logic [29:0] bus_addr;
   int checks = 0, passed = 0;
   bus_arb #(.TOUT_CYC(TC), .TOUT_W(TW)) dut (
      .clk(clk), .rst(rst),
      .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dout(m0_dout),
      .m0_din(m0_din), .m0_ack(m0_ack),
      .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dout(m1_dout),
      .m1_din(m1_din), .m1_ack(m1_ack),
      .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
      .bus_din(bus_din), .bus_ack(bus_ack), .tout_irq(tout_irq)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      rst = 1'b1;
      m0_stb = 0; m0_we = 0; m0_addr = A0; m0_dout = 32'hA0A0A0A0;
      m1_stb = 0; m1_we = 0; m1_addr = A1; m1_dout = 32'hB1B1B1B1;
      bus_ack = 0; bus_din = 32'h0;
      tick; tick;
      rst = 1'b0;
   endtask
   task automatic test_reset;
      do_reset;
      bus_din = 32'hFFFFFFFF;
      @(negedge clk);
      checks++;
      if ({bus_stb, bus_we, bus_addr, bus_dout, m0_ack, m1_ack, m0_din, m1_din, tout_irq} !== '0)
         $display("FAIL reset_outputs stb=%b we=%b addr=%h dout=%h din0=%h din1=%h exp all zero",
                  bus_stb, bus_we, bus_addr, bus_dout, m0_din, m1_din);
      else passed++;
   endtask
   task automatic test_single_read;
      do_reset;
      m0_stb = 1;
      @(negedge clk);
      checks++;
      if (bus_stb !== 1'b0) $display("FAIL read_c0_stb got %b exp 0", bus_stb); else passed++;
      for (int c = 1; c <= 3; c++) begin
         tick;
         if (c == 3) begin bus_ack = 1; bus_din = 32'hDEADBEEF; end
         @(negedge clk);
         checks++;
         if (bus_stb !== 1'b1 || bus_addr !== A0 || bus_we !== 1'b0)
            $display("FAIL read_c%0d_bus stb=%b addr=%h we=%b exp 1 %h 0", c, bus_stb, bus_addr, bus_we, A0);
         else passed++;
         checks++;
         if (m0_ack !== (c == 3) || m1_ack !== 1'b0)
            $display("FAIL read_c%0d_ack m0=%b m1=%b exp %b 0", c, m0_ack, m1_ack, c == 3);
         else passed++;
      end
      checks++;
      if (m0_din !== 32'hDEADBEEF || m1_din !== 32'h0)
         $display("FAIL read_din m0=%h m1=%h exp deadbeef 0", m0_din, m1_din);
      else passed++;
      tick;
      m0_stb = 0; bus_ack = 0;
      @(negedge clk);
      checks++;
      if (bus_stb !== 1'b0 || m0_ack !== 1'b0) $display("FAIL read_after stb=%b ack=%b exp 0 0", bus_stb, m0_ack);
      else passed++;
   endtask
   task automatic test_back_to_back;
      int own;
      logic es;
      do_reset;
      m0_stb = 1; m1_stb = 1;
      for (int c = 1; c <= 12; c++) begin
         tick;
         bus_ack = (c % 3 != 1);
         bus_din = 32'h100 + c;
         @(negedge clk);
         es  = (c % 3 != 0);
         own = ((c - 1) / 3) % 2;
         checks++;
         if (bus_stb !== es) $display("FAIL b2b_c%0d_stb got %b exp %b", c, bus_stb, es); else passed++;
         if (es) begin
            checks++;
            if (bus_addr !== (own ? A1 : A0))
               $display("FAIL b2b_c%0d_addr got %h exp %h", c, bus_addr, own ? A1 : A0);
            else passed++;
         end
         checks++;
         if (m0_ack !== (c % 3 == 2 && own == 0) || m1_ack !== (c % 3 == 2 && own == 1))
            $display("FAIL b2b_c%0d_ack m0=%b m1=%b exp %b %b", c, m0_ack, m1_ack,
                     c % 3 == 2 && own == 0, c % 3 == 2 && own == 1);
         else passed++;
      end
      m0_stb = 0; m1_stb = 0; bus_ack = 0;
   endtask
   task automatic test_write_hold;
      do_reset;
      m1_stb = 1; m1_we = 1; m1_dout = 32'h12345678;
      tick;
      m0_stb = 1;
      for (int c = 1; c <= 3; c++) begin
         if (c == 3) bus_ack = 1;
         @(negedge clk);
         checks++;
         if (bus_dout !== 32'h12345678 || bus_we !== 1'b1 || bus_addr !== A1 || bus_stb !== 1'b1)
            $display("FAIL wr_c%0d dout=%h we=%b addr=%h stb=%b exp 12345678 1 %h 1", c, bus_dout, bus_we, bus_addr, bus_stb, A1);
         else passed++;
         checks++;
         if (m0_ack !== 1'b0 || m1_ack !== (c == 3))
            $display("FAIL wr_c%0d_ack m0=%b m1=%b exp 0 %b", c, m0_ack, m1_ack, c == 3);
         else passed++;
         tick;
      end
      m1_stb = 0; bus_ack = 0;
      @(negedge clk);
      checks++;
      if (bus_stb !== 1'b0 || bus_dout !== 32'h0) $display("FAIL wr_dead stb=%b dout=%h exp 0 0", bus_stb, bus_dout);
      else passed++;
      tick;
      @(negedge clk);
      checks++;
      if (bus_stb !== 1'b1 || bus_addr !== A0 || bus_we !== 1'b0)
         $display("FAIL wr_m0_gnt stb=%b addr=%h we=%b exp 1 %h 0", bus_stb, bus_addr, bus_we, A0);
      else passed++;
      m0_stb = 0;
   endtask
   task automatic test_reset_mid;
      do_reset;
      m1_stb = 1;
      tick;
      @(negedge clk);
      checks++;
      if (bus_stb !== 1'b1 || bus_addr !== A1) $display("FAIL rst_mid_gnt1 stb=%b addr=%h exp 1 %h", bus_stb, bus_addr, A1);
      else passed++;
      tick;
      rst = 1; m0_stb = 1;
      tick;
      rst = 0; bus_ack = 1;
      @(negedge clk);
      checks++;
      if (bus_stb !== 1'b0 || m1_ack !== 1'b0 || m0_ack !== 1'b0 || bus_addr !== '0 || tout_irq !== 1'b0)
         $display("FAIL rst_mid_idle stb=%b m1_ack=%b m0_ack=%b addr=%h irq=%b exp all 0", bus_stb, m1_ack, m0_ack, bus_addr, tout_irq);
      else passed++;
      tick;
      bus_ack = 0;
      @(negedge clk);
      checks++;
      if (bus_stb !== 1'b1 || bus_addr !== A0) $display("FAIL rst_mid_tie stb=%b addr=%h exp 1 %h", bus_stb, bus_addr, A0);
      else passed++;
      m0_stb = 0; m1_stb = 0;
   endtask
   task automatic test_abort;
      do_reset;
      m0_stb = 1;
      tick;
      m1_stb = 1;
      @(negedge clk);
      checks++;
      if (bus_stb !== 1'b1 || bus_addr !== A0) $display("FAIL abort_gnt0 stb=%b addr=%h exp 1 %h", bus_stb, bus_addr, A0);
      else passed++;
      tick;
      m0_stb = 0;
      @(negedge clk);
      checks++;
      if (bus_stb !== 1'b0 || m0_ack !== 1'b0) $display("FAIL abort_drop stb=%b ack=%b exp 0 0", bus_stb, m0_ack);
      else passed++;
      tick;
      @(negedge clk);
      checks++;
      if (bus_stb !== 1'b0 || bus_addr !== '0) $display("FAIL abort_idle stb=%b addr=%h exp 0 0", bus_stb, bus_addr);
      else passed++;
      tick;
      @(negedge clk);
      checks++;
      if (bus_stb !== 1'b1 || bus_addr !== A1) $display("FAIL abort_gnt1 stb=%b addr=%h exp 1 %h", bus_stb, bus_addr, A1);
      else passed++;
      m1_stb = 0;
   endtask
`ifdef BUS_ARB_TIMEOUT_EN
   task automatic test_timeout;
      do_reset;
      m0_stb = 1; bus_din = 32'hFFFFFFFF;
      for (int c = 1; c <= 8; c++) begin
         tick;
         @(negedge clk);
         checks++;
         if (tout_irq !== (c == 8) || m0_ack !== (c == 8) || bus_stb !== (c != 8))
            $display("FAIL tout_c%0d irq=%b ack=%b stb=%b exp %b %b %b", c, tout_irq, m0_ack, bus_stb, c == 8, c == 8, c != 8);
         else passed++;
      end
      checks++;
      if (m0_din !== 32'h0) $display("FAIL tout_din got %h exp 0", m0_din); else passed++;
      tick;
      for (int c = 1; c <= 8; c++) begin
         tick;
         if (c == 8) begin bus_ack = 1; bus_din = 32'hCAFEF00D; end
         @(negedge clk);
         checks++;
         if (tout_irq !== 1'b0 || m0_ack !== (c == 8))
            $display("FAIL tout_ack_c%0d irq=%b ack=%b exp 0 %b", c, tout_irq, m0_ack, c == 8);
         else passed++;
      end
      checks++;
      if (m0_din !== 32'hCAFEF00D || bus_stb !== 1'b1) $display("FAIL tout_ack_din din=%h stb=%b exp cafef00d 1", m0_din, bus_stb);
      else passed++;
      tick;
      m0_stb = 0; bus_ack = 0;
   endtask
`else
   task automatic test_timeout;
      do_reset;
      m0_stb = 1;
      for (int c = 1; c <= 20; c++) begin
         tick;
         @(negedge clk);
         checks++;
         if (tout_irq !== 1'b0 || m0_ack !== 1'b0 || bus_stb !== 1'b1)
            $display("FAIL notout_c%0d irq=%b ack=%b stb=%b exp 0 0 1", c, tout_irq, m0_ack, bus_stb);
         else passed++;
      end
      tick;
      m0_stb = 0;
   endtask
`endif
   initial begin
      test_reset;
      test_single_read;
      test_back_to_back;
      test_write_hold;
      test_reset_mid;
      test_abort;
      test_timeout;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
